// File: rtl/prm_edge_mask_accum.sv
// prm_edge_mask_accum: collects per-edge obstacle masks from the checker array
// into a blocked-edge bitmap, then drains it as WORD_W-bit words with a count.
module prm_edge_mask_accum #(
  parameter int unsigned NUM_EDGES = 1024,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned VOX_W     = 15,
  localparam int unsigned NUM_WORDS = (NUM_EDGES + WORD_W - 1) / WORD_W,
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned CNT_W     = $clog2(NUM_EDGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vox_valid,
  output logic                 vox_ready,
  input  logic [VOX_W-1:0]     vox_code,
  input  logic                 vox_last,
  output logic [VOX_W-1:0]     chk_code,
  input  logic [NUM_EDGES-1:0] chk_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_W-1:0]    out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [CNT_W-1:0]     blocked_cnt,
  output logic                 busy
);

  localparam int unsigned PAD_W = NUM_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

  state_t               state, state_n;
  logic [NUM_EDGES-1:0] bitmap;
  logic [PAD_W-1:0]     bitmap_pad;
  logic                 pend;        // a voxel was accepted last cycle; its mask is on chk_mask now
  logic                 accept;
  logic                 hs;
  logic [CNT_W-1:0]     run_cnt;
  logic [CNT_W-1:0]     word_pc;

  // Next-state and handshake decode
  always_comb begin
    state_n   = state;
    vox_ready = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    hs        = 1'b0;
    unique case (state)
      ACCUM: begin
        vox_ready = 1'b1;
        accept    = vox_valid;
        if (vox_valid && vox_last) state_n = FLUSH;
      end
      FLUSH: state_n = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        hs        = out_ready;
        if (out_ready && out_last) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  assign busy     = (state != ACCUM);
  assign out_last = (state == DRAIN) && (out_idx == LAST_IDX);

  // Zero-pad the bitmap to whole words so the last word reads 0 above NUM_EDGES
  always_comb begin
    bitmap_pad                  = '0;
    bitmap_pad[NUM_EDGES-1:0]   = bitmap;
    out_data = bitmap_pad[int'(out_idx) * WORD_W +: WORD_W];
  end

  // Population count of the word currently presented
  always_comb begin
    word_pc = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      word_pc = word_pc + CNT_W'(out_data[i]);
    end
  end

  // State, code pipeline, bitmap accumulation and drain bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      bitmap      <= '0;
      chk_code    <= '0;
      pend        <= 1'b0;
      out_idx     <= '0;
      run_cnt     <= '0;
      blocked_cnt <= '0;
    end else begin
      state <= state_n;
      pend  <= accept;
      if (accept) begin
        chk_code    <= vox_code;
        blocked_cnt <= '0;
      end
      if (hs) begin
        if (out_last) begin
          bitmap      <= '0;
          out_idx     <= '0;
          run_cnt     <= '0;
          blocked_cnt <= run_cnt + word_pc;
        end else begin
          out_idx <= out_idx + 1'b1;
          run_cnt <= run_cnt + word_pc;
        end
      end else if (pend) begin
        bitmap <= bitmap | chk_mask;
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Directed bench for prm_edge_mask_accum with a table of frames and a
// behavioural checker-array model keyed on chk_code.
module tb_prm_edge_mask_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic         vox_valid, vox_ready, vox_last;
  logic [14:0]  vox_code, chk_code;
  logic [1023:0] chk_mask;
  logic         out_valid, out_ready, out_last, busy;
  logic [31:0]  out_data;
  logic [4:0]   out_idx;
  logic [10:0]  blocked_cnt;

  logic         b_vox_valid, b_vox_ready, b_vox_last;
  logic [14:0]  b_vox_code, b_chk_code;
  logic [39:0]  b_chk_mask;
  logic         b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [31:0]  b_out_data;
  logic [0:0]   b_out_idx;
  logic [5:0]   b_blocked_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prm_edge_mask_accum #(.NUM_EDGES(1024), .WORD_W(32), .VOX_W(15)) dut (
    .clk(clk), .rst(rst), .vox_valid(vox_valid), .vox_ready(vox_ready),
    .vox_code(vox_code), .vox_last(vox_last), .chk_code(chk_code),
    .chk_mask(chk_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .blocked_cnt(blocked_cnt), .busy(busy));

  prm_edge_mask_accum #(.NUM_EDGES(40), .WORD_W(32), .VOX_W(15)) dut40 (
    .clk(clk), .rst(rst), .vox_valid(b_vox_valid), .vox_ready(b_vox_ready),
    .vox_code(b_vox_code), .vox_last(b_vox_last), .chk_code(b_chk_code),
    .chk_mask(b_chk_mask), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last),
    .blocked_cnt(b_blocked_cnt), .busy(b_busy));

  // Checker array model: one-hot edge flags per voxel code
  function automatic logic [1023:0] mask_of(input logic [14:0] c);
    logic [1023:0] m;
    m = '0;
    case (c)
      15'd1: begin m[0] = 1'b1; m[5] = 1'b1; m[1023] = 1'b1; end
      15'd2: m[1] = 1'b1;
      15'd3: begin m[1] = 1'b1; m[2] = 1'b1; end
      15'd4: m[40] = 1'b1;
      15'd5: begin m[0] = 1'b1; m[63] = 1'b1; end
      15'd6: m[33] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  always_comb chk_mask   = mask_of(chk_code);
  always_comb b_chk_mask = (b_chk_code == 15'd7) ? (40'd1 << 39) : 40'd0;

  typedef struct {
    int          n;
    logic [14:0] c[3];
    logic [31:0] w0, w1, w31;
    int          cnt;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      int k;
      @(negedge clk);
      vox_valid = 1'b1;
      vox_code  = v.c[i];
      vox_last  = (i == v.n - 1);
      k = 0;
      while (!vox_ready && k < 100) begin @(negedge clk); k++; end
    end
    @(negedge clk);
    vox_valid = 1'b0;
    vox_last  = 1'b0;
  endtask

  // Drain all 32 words and check them; optional backpressure, held producer, or reset at stop_at
  task automatic drain(input vec_t v, input bit rnd, input bit held, input int stop_at);
    int k, idx;
    logic [31:0] exp;
    k = 0;
    idx = 0;
    while (!out_valid && k < 50) begin
      if (held) chk("vox_ready_flush", vox_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("out_valid_up", out_valid, 1);
    while (idx < 32 && k < 400) begin
      if (idx == stop_at) begin
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_blocked_cnt", blocked_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vox_ready", vox_ready, 1);
        chk("rst_out_idx", out_idx, 0);
        return;
      end
      exp = (idx == 0) ? v.w0 : (idx == 1) ? v.w1 : (idx == 31) ? v.w31 : 32'h0;
      chk("out_valid", out_valid, 1);
      chk("out_idx", out_idx, idx);
      chk("out_data", out_data, exp);
      chk("out_last", out_last, (idx == 31));
      if (held) chk("vox_ready_drain", vox_ready, 0);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) idx++;
      @(negedge clk);
      k++;
    end
    out_ready = 1'b0;
    chk("words_delivered", idx, 32);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_vox_ready", vox_ready, 1);
    chk("blocked_cnt", blocked_cnt, v.cnt);
  endtask

  initial begin
    vec_t v6, v4;
    int k;
    rst = 1'b1;
    vox_valid = 1'b0; vox_code = '0; vox_last = 1'b0; out_ready = 1'b0;
    b_vox_valid = 1'b0; b_vox_code = '0; b_vox_last = 1'b0; b_out_ready = 1'b0;

    tbl[0] = '{1, '{15'd1, 15'd0, 15'd0}, 32'h0000_0021, 32'h0,         32'h8000_0000, 3};
    tbl[1] = '{3, '{15'd2, 15'd3, 15'd4}, 32'h0000_0006, 32'h0000_0100, 32'h0,         3};
    tbl[2] = '{3, '{15'd5, 15'd5, 15'd6}, 32'h0000_0001, 32'h8000_0002, 32'h0,         3};
    tbl[3] = '{1, '{15'd6, 15'd0, 15'd0}, 32'h0,         32'h0000_0002, 32'h0,         1};
    v6 = tbl[3];
    v4 = '{1, '{15'd4, 15'd0, 15'd0}, 32'h0, 32'h0000_0100, 32'h0, 1};

    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_vox_ready", vox_ready, 1);
    chk("reset_chk_code", chk_code, 0);
    chk("reset_blocked_cnt", blocked_cnt, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_last", out_last, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      send(tbl[i]);
      drain(tbl[i], (i == 2), 1'b0, -1);
    end

    // producer holds a voxel through FLUSH/DRAIN
    send(tbl[0]);
    vox_valid = 1'b1; vox_code = 15'd6; vox_last = 1'b1;
    drain(tbl[0], 1'b0, 1'b1, -1);
    @(negedge clk);
    vox_valid = 1'b0; vox_last = 1'b0;
    chk("cnt_clear_on_accept", blocked_cnt, 0);
    chk("busy_after_accept", busy, 1);
    drain(v6, 1'b0, 1'b0, -1);

    // reset mid-drain at idx 7, then a fresh frame
    send(tbl[0]);
    drain(tbl[0], 1'b0, 1'b0, 7);
    send(v4);
    drain(v4, 1'b1, 1'b0, -1);

    // NUM_EDGES=40 instance: padding bits of the last word
    @(negedge clk);
    b_vox_valid = 1'b1; b_vox_code = 15'd7; b_vox_last = 1'b1;
    @(negedge clk);
    b_vox_valid = 1'b0; b_vox_last = 1'b0;
    k = 0;
    while (!b_out_valid && k < 50) begin @(negedge clk); k++; end
    chk("e40_out_valid", b_out_valid, 1);
    chk("e40_idx0", b_out_idx, 0);
    chk("e40_word0", b_out_data, 32'h0);
    chk("e40_last0", b_out_last, 0);
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("e40_idx1", b_out_idx, 1);
    chk("e40_word1", b_out_data, 32'h0000_0080);
    chk("e40_last1", b_out_last, 1);
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("e40_done_valid", b_out_valid, 0);
    chk("e40_blocked_cnt", b_blocked_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
